// File: rtl/apb_timer_pkg.sv
// Shared definitions for the APB machine timer: register offsets, CTRL bit
// positions, FSM encoding and the address decoder.
package apb_timer_pkg;

  localparam logic [4:0] OFF_MTIME_LO    = 5'h00;
  localparam logic [4:0] OFF_MTIME_HI    = 5'h04;
  localparam logic [4:0] OFF_MTIMECMP_LO = 5'h08;
  localparam logic [4:0] OFF_MTIMECMP_HI = 5'h0C;
  localparam logic [4:0] OFF_CTRL        = 5'h10;
  localparam logic [4:0] OFF_PRESCALE    = 5'h14;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_IRQ_EN = 1;

  localparam int PRESCALE_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } apb_state_e;

  // One-hot register select; all-zero means unmapped or misaligned.
  typedef struct packed {
    logic mtime_lo;
    logic mtime_hi;
    logic cmp_lo;
    logic cmp_hi;
    logic ctrl;
    logic prescale;
  } reg_sel_t;

  // Full 5-bit compare, so any nonzero paddr[1:0] falls through to unmapped.
  function automatic reg_sel_t decode_offset(input logic [4:0] off);
    reg_sel_t s;
    s = '0;
    case (off)
      OFF_MTIME_LO:    s.mtime_lo = 1'b1;
      OFF_MTIME_HI:    s.mtime_hi = 1'b1;
      OFF_MTIMECMP_LO: s.cmp_lo   = 1'b1;
      OFF_MTIMECMP_HI: s.cmp_hi   = 1'b1;
      OFF_CTRL:        s.ctrl     = 1'b1;
      OFF_PRESCALE:    s.prescale = 1'b1;
      default:         s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/apb_timer_if.sv
// APB bus bundle between the core's initiator and the timer completer.
interface apb_timer_if #(
  parameter int ADDR_W = 8
);
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [31:0]       pwdata;
  logic [31:0]       prdata;
  logic              pready;
  logic              perr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, perr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, perr
  );
endinterface

// File: rtl/timer_counter.sv
// Prescaled 64-bit mtime counter, mtimecmp register and the registered
// compare that drives the machine timer interrupt.
module timer_counter
  import apb_timer_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  irq_en,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  wr_mtime_lo,
  input  logic                  wr_mtime_hi,
  input  logic                  wr_cmp_lo,
  input  logic                  wr_cmp_hi,
  input  logic                  wr_prescale,
  input  logic [31:0]           wdata,
  output logic [63:0]           mtime,
  output logic [63:0]           mtimecmp,
  output logic                  irq
);

  logic [PRESCALE_W-1:0] pre_cnt_q;
  logic [63:0]           mtime_q;
  logic [63:0]           cmp_q;
  logic                  irq_q;
  logic                  tick;

  // The counter never exceeds PRESCALE because a PRESCALE write clears it.
  assign tick = en && (pre_cnt_q == prescale);

  // NOTE: every register here uses <= so all of them sample the pre-edge
  // values; a blocking = would let later statements see half-updated state.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt_q <= '0;
    end else if (wr_prescale) begin
      pre_cnt_q <= '0;
    end else if (en) begin
      pre_cnt_q <= tick ? '0 : pre_cnt_q + PRESCALE_W'(1);
    end
  end

  // A software write to either half wins and drops that cycle's increment,
  // including any carry into the other half.
  always_ff @(posedge clk) begin
    if (rst) begin
      mtime_q <= '0;
    end else if (wr_mtime_lo) begin
      mtime_q[31:0] <= wdata;
    end else if (wr_mtime_hi) begin
      mtime_q[63:32] <= wdata;
    end else if (tick) begin
      mtime_q <= mtime_q + 64'd1;
    end
  end

  // NOTE: mtimecmp resets to all-ones (not zero) so the compare is false out
  // of reset and the interrupt cannot fire before software programs it.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmp_q <= '1;
    end else begin
      if (wr_cmp_lo) cmp_q[31:0]  <= wdata;
      if (wr_cmp_hi) cmp_q[63:32] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_en && (mtime_q >= cmp_q);
    end
  end

  assign mtime    = mtime_q;
  assign mtimecmp = cmp_q;
  assign irq      = irq_q;

endmodule

// File: rtl/apb_timer.sv
// APB completer for the RISC-V style machine timer: transfer FSM with
// programmable wait states, register decode and the tear-free mtime snapshot.
module apb_timer
  import apb_timer_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 0,
  parameter int HAS_PENABLE = 1
) (
  input  logic        APB_PCLK,
  input  logic        APB_PRESET,
  apb_timer_if.slave  apb,
  output logic        interrupt
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  apb_state_e state_q, state_d;
  logic [3:0] wait_q, wait_d;

  logic setup_ok;
  logic access_ok;

  // Without penable the initiator ties it to psel, so psel alone qualifies both phases.
  assign setup_ok  = apb.psel && ((HAS_PENABLE == 0) || !apb.penable);
  assign access_ok = apb.psel && ((HAS_PENABLE == 0) ||  apb.penable);

  // NOTE: defaults are assigned before the case so no path leaves a signal
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    unique case (state_q)
      ST_IDLE: begin
        if (setup_ok) begin
          if (WAIT_STATES == 0) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            wait_d  = WAIT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (!apb.psel) begin
          state_d = ST_IDLE;
        end else if (access_ok) begin
          wait_d = wait_q - 4'd1;
          if (wait_q == 4'd1) state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge APB_PCLK) begin
    if (APB_PRESET) begin
      state_q <= ST_IDLE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  logic     upper_nz;
  reg_sel_t sel;
  logic     addr_err;
  logic     in_resp;
  logic     wr_en;
  logic     rd_lo;

  if (ADDR_W > 5) begin : g_upper
    assign upper_nz = |apb.paddr[ADDR_W-1:5];
  end else begin : g_no_upper
    assign upper_nz = 1'b0;
  end

  assign sel      = upper_nz ? '0 : decode_offset(apb.paddr[4:0]);
  assign addr_err = (sel == '0);
  assign in_resp  = (state_q == ST_RESP);
  assign wr_en    = in_resp && apb.pwrite && !addr_err;
  assign rd_lo    = in_resp && !apb.pwrite && sel.mtime_lo;

  logic [1:0]            ctrl_q;
  logic [PRESCALE_W-1:0] prescale_q;
  logic [31:0]           snap_q;
  logic [63:0]           mtime;
  logic [63:0]           mtimecmp;

  always_ff @(posedge APB_PCLK) begin
    if (APB_PRESET) begin
      ctrl_q     <= '0;
      prescale_q <= '0;
      snap_q     <= '0;
    end else begin
      if (wr_en && sel.ctrl)     ctrl_q     <= apb.pwdata[1:0];
      if (wr_en && sel.prescale) prescale_q <= apb.pwdata[PRESCALE_W-1:0];
      // Reading LO freezes the upper half so a following HI read cannot tear.
      if (rd_lo)                 snap_q     <= mtime[63:32];
    end
  end

  timer_counter u_counter (
    .clk        (APB_PCLK),
    .rst        (APB_PRESET),
    .en         (ctrl_q[CTRL_EN]),
    .irq_en     (ctrl_q[CTRL_IRQ_EN]),
    .prescale   (prescale_q),
    .wr_mtime_lo(wr_en && sel.mtime_lo),
    .wr_mtime_hi(wr_en && sel.mtime_hi),
    .wr_cmp_lo  (wr_en && sel.cmp_lo),
    .wr_cmp_hi  (wr_en && sel.cmp_hi),
    .wr_prescale(wr_en && sel.prescale),
    .wdata      (apb.pwdata),
    .mtime      (mtime),
    .mtimecmp   (mtimecmp),
    .irq        (interrupt)
  );

  logic [31:0] rdata;

  always_comb begin
    rdata = '0;
    if (sel.mtime_lo) rdata = mtime[31:0];
    if (sel.mtime_hi) rdata = snap_q;
    if (sel.cmp_lo)   rdata = mtimecmp[31:0];
    if (sel.cmp_hi)   rdata = mtimecmp[63:32];
    if (sel.ctrl)     rdata = {30'd0, ctrl_q};
    if (sel.prescale) rdata = {{(32 - PRESCALE_W){1'b0}}, prescale_q};
  end

  // rdata is already zero for an unmapped select, so errors return prdata=0.
  assign apb.pready = in_resp;
  assign apb.perr   = in_resp && addr_err;
  assign apb.prdata = in_resp ? rdata : '0;

endmodule

// File: tb/tb_apb_timer.sv
// Self-checking bench for apb_timer: a cycle-level reference model of the
// timer registers feeds an expected-response queue drained by a bus monitor.
module tb_apb_timer;
  import apb_timer_pkg::*;

  localparam int ADDR_W = 8;
  localparam int WS     = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic irq;
  logic irq2;

  always #5 clk = ~clk;

  apb_timer_if #(.ADDR_W(ADDR_W)) bus  ();
  apb_timer_if #(.ADDR_W(ADDR_W)) bus2 ();

  apb_timer #(.ADDR_W(ADDR_W), .WAIT_STATES(WS), .HAS_PENABLE(1)) dut (
    .APB_PCLK  (clk),
    .APB_PRESET(rst),
    .apb       (bus),
    .interrupt (irq)
  );

  apb_timer #(.ADDR_W(ADDR_W), .WAIT_STATES(0), .HAS_PENABLE(0)) dut_np (
    .APB_PCLK  (clk),
    .APB_PRESET(rst),
    .apb       (bus2),
    .interrupt (irq2)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [63:0] mtime;
    logic [63:0] cmp;
    logic [1:0]  ctrl;
    logic [15:0] pre;
    logic [15:0] cnt;
    logic [31:0] snap;
    logic        irq;
  } mdl_t;

  mdl_t m;

  bit          r_now = 1'b0;
  bit          r_wr  = 1'b0;
  logic [7:0]  r_addr = '0;
  logic [31:0] r_data = '0;

  function automatic bit addr_err(input logic [7:0] a);
    return (a[1:0] != 2'b00) || (a[7:5] != 3'b000) || (a[4:2] > 3'd5);
  endfunction

  function automatic logic [31:0] model_read(input mdl_t s, input logic [7:0] a);
    if (addr_err(a)) return 32'h0;
    case (a[4:2])
      3'd0:    return s.mtime[31:0];
      3'd1:    return s.snap;
      3'd2:    return s.cmp[31:0];
      3'd3:    return s.cmp[63:32];
      3'd4:    return {30'd0, s.ctrl};
      3'd5:    return {16'd0, s.pre};
      default: return 32'h0;
    endcase
  endfunction

  // One clock of timer behaviour: prescaled counting, interrupt from current
  // values, and the effect of a completing transfer if there is one.
  function automatic mdl_t model_next(input mdl_t s, input bit resp, input bit wr,
                                      input logic [7:0] a, input logic [31:0] d);
    mdl_t n;
    bit   inc;
    n   = s;
    inc = s.ctrl[0] && (s.cnt == s.pre);
    if (s.ctrl[0]) n.cnt = inc ? 16'd0 : s.cnt + 16'd1;
    if (inc) n.mtime = s.mtime + 64'd1;
    n.irq = s.ctrl[1] && (s.mtime >= s.cmp);
    if (resp && !addr_err(a)) begin
      if (wr) begin
        case (a[4:2])
          3'd0: n.mtime = {s.mtime[63:32], d};
          3'd1: n.mtime = {d, s.mtime[31:0]};
          3'd2: n.cmp[31:0]  = d;
          3'd3: n.cmp[63:32] = d;
          3'd4: n.ctrl = d[1:0];
          3'd5: begin n.pre = d[15:0]; n.cnt = 16'd0; end
          default: ;
        endcase
      end else if (a[4:2] == 3'd0) begin
        n.snap = s.mtime[63:32];
      end
    end
    return n;
  endfunction

  always @(posedge clk) begin
    if (rst) m <= '{mtime: 64'd0, cmp: {64{1'b1}}, ctrl: 2'd0, pre: 16'd0,
                    cnt: 16'd0, snap: 32'd0, irq: 1'b0};
    else     m <= model_next(m, r_now, r_wr, r_addr, r_data);
    cyc <= cyc + 1;
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    int          cyc;
    bit          chk;
    logic [31:0] data;
    bit          err;
  } exp_t;

  exp_t q[$];
  exp_t q2[$];

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (cyc > 0) begin
        check("interrupt", 64'(irq), 64'(m.irq));
        if (bus.pready === 1'b1) begin
          if (q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_pready: actual=1 required=0 (cycle %0d)", cyc);
          end else begin
            e = q.pop_front();
            check("pready_cycle", 64'(cyc), 64'(e.cyc));
            check("perr", 64'(bus.perr), 64'(e.err));
            if (e.chk) check("prdata", 64'(bus.prdata), 64'(e.data));
          end
        end else begin
          check("idle_outputs", 64'({bus.perr, bus.prdata}), 64'd0);
          if (q.size() > 0 && q[0].cyc < cyc) begin
            checks++; errors++;
            $display("FAIL missing_pready: actual=none required=pready at cycle %0d", q[0].cyc);
            e = q.pop_front();
          end
        end
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (cyc > 0) begin
        check("interrupt_np", 64'(irq2), 64'd0);
        if (bus2.pready === 1'b1) begin
          if (q2.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_pready_np: actual=1 required=0 (cycle %0d)", cyc);
          end else begin
            e = q2.pop_front();
            check("pready_cycle_np", 64'(cyc), 64'(e.cyc));
            check("perr_np", 64'(bus2.perr), 64'(e.err));
            check("prdata_np", 64'(bus2.prdata), 64'(e.data));
          end
        end else begin
          check("idle_outputs_np", 64'({bus2.perr, bus2.prdata}), 64'd0);
          if (q2.size() > 0 && q2[0].cyc < cyc) begin
            checks++; errors++;
            $display("FAIL missing_pready_np: actual=none required=pready at cycle %0d", q2[0].cyc);
            e = q2.pop_front();
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Called just after a clock edge; the transfer completes WS+1 cycles after setup.
  task automatic xfer(input bit wr, input logic [7:0] addr, input logic [31:0] data,
                      input bit abort);
    exp_t e;
    bus.psel    = 1'b1;
    bus.penable = 1'b0;
    bus.pwrite  = wr;
    bus.paddr   = addr;
    bus.pwdata  = data;
    @(posedge clk); #1;
    bus.penable = 1'b1;
    if (abort) begin
      @(posedge clk); #1;
      bus.psel    = 1'b0;
      bus.penable = 1'b0;
      @(posedge clk); #1;
      return;
    end
    repeat (WS) begin @(posedge clk); #1; end
    e.cyc  = cyc;
    e.err  = addr_err(addr);
    e.chk  = !wr || e.err;
    e.data = wr ? 32'h0 : model_read(m, addr);
    q.push_back(e);
    r_now  = 1'b1;
    r_wr   = wr;
    r_addr = addr;
    r_data = data;
    @(posedge clk); #1;
    r_now       = 1'b0;
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
  endtask

  task automatic wr(input logic [4:0] off, input logic [31:0] d);
    xfer(1'b1, 8'(off), d, 1'b0);
  endtask

  task automatic rd(input logic [4:0] off);
    xfer(1'b0, 8'(off), $urandom, 1'b0);
  endtask

  logic [7:0] bad_addrs [7] = '{8'h18, 8'h1C, 8'h02, 8'h01, 8'h20, 8'h84, 8'hE8};
  logic [7:0] np_addrs  [8] = '{8'h08, 8'h10, 8'h14, 8'h18, 8'h0C, 8'h00, 8'h04, 8'h02};

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0]  a;
    logic [31:0] d;
    exp_t        e;

    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = '0; bus.pwdata = '0;
    bus2.psel = 1'b0; bus2.penable = 1'b0; bus2.pwrite = 1'b0; bus2.paddr = '0; bus2.pwdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    idle(10);

    // Reset values
    rd(OFF_MTIMECMP_LO); rd(OFF_MTIMECMP_HI); rd(OFF_CTRL);
    rd(OFF_PRESCALE);    rd(OFF_MTIME_LO);    rd(OFF_MTIME_HI);

    // CTRL write with wait states, then an aborted write that must not land
    wr(OFF_CTRL, 32'hFFFF_FFF3); rd(OFF_CTRL);
    xfer(1'b1, 8'(OFF_CTRL), 32'h0, 1'b1);
    idle(2);
    rd(OFF_CTRL);

    // Carry across the halves and snapshot read
    wr(OFF_CTRL, 32'h0); wr(OFF_PRESCALE, 32'h0); wr(OFF_MTIME_HI, 32'h0);
    wr(OFF_CTRL, 32'h1); wr(OFF_MTIME_LO, 32'hFFFF_FFFF);
    rd(OFF_MTIME_LO); rd(OFF_MTIME_HI);

    // Writes that collide with a running increment
    wr(OFF_MTIME_LO, 32'h1234_5678); rd(OFF_MTIME_LO);
    wr(OFF_MTIME_HI, 32'hDEAD_BEEF); rd(OFF_MTIME_LO); rd(OFF_MTIME_HI);
    wr(OFF_CTRL, 32'h0); wr(OFF_MTIME_LO, 32'hCAFE_F00D); rd(OFF_MTIME_LO);

    // Interrupt rise at mtime >= 5 with prescale 1, fall after mtimecmp raise
    wr(OFF_MTIME_HI, 32'h0); wr(OFF_MTIME_LO, 32'h0);
    wr(OFF_MTIMECMP_HI, 32'h0); wr(OFF_MTIMECMP_LO, 32'd5);
    wr(OFF_PRESCALE, 32'hABCD_0001); rd(OFF_PRESCALE);
    wr(OFF_CTRL, 32'h3);
    idle(16);
    wr(OFF_MTIMECMP_LO, 32'd100);
    idle(4);

    // Unmapped and misaligned accesses
    foreach (bad_addrs[i]) begin
      xfer(1'b1, bad_addrs[i], $urandom, 1'b0);
      xfer(1'b0, bad_addrs[i], $urandom, 1'b0);
    end
    wr(OFF_CTRL, 32'h0);
    for (int i = 0; i < 6; i++) rd(5'(i * 4));

    // Randomized traffic, including back-to-back transfers and aborts
    wr(OFF_CTRL, 32'h3);
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 3) == 0) a = bad_addrs[$urandom_range(0, 6)];
      else                           a = 8'($urandom_range(0, 5) * 4);
      d = $urandom;
      if (a == 8'(OFF_PRESCALE)) d[15:0] = 16'($urandom_range(0, 3));
      xfer(1'($urandom_range(0, 1)), a, d, ($urandom_range(0, 7) == 0));
      idle($urandom_range(0, 2));
    end

    // Reset in the middle of a transfer: no pready, no side effect
    wr(OFF_PRESCALE, 32'h0);
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
    bus.paddr = 8'(OFF_PRESCALE); bus.pwdata = 32'h7;
    @(posedge clk); #1; bus.penable = 1'b1;
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1; rst = 1'b0; bus.psel = 1'b0; bus.penable = 1'b0;
    idle(2);
    rd(OFF_PRESCALE); rd(OFF_CTRL); rd(OFF_MTIME_LO); rd(OFF_MTIMECMP_HI);

    // No-penable instance: back-to-back reads with psel held high
    bus2.psel = 1'b1; bus2.penable = 1'b1; bus2.pwrite = 1'b0;
    foreach (np_addrs[i]) begin
      bus2.paddr  = np_addrs[i];
      bus2.pwdata = $urandom;
      e.cyc  = cyc + 1;
      e.chk  = 1'b1;
      e.err  = addr_err(np_addrs[i]);
      case (np_addrs[i])
        8'h08, 8'h0C: e.data = 32'hFFFF_FFFF;
        default:      e.data = 32'h0;
      endcase
      q2.push_back(e);
      @(posedge clk); #1;
      @(posedge clk); #1;
    end
    bus2.psel = 1'b0; bus2.penable = 1'b0;

    idle(5);
    check("queues_drained", 64'(q.size() + q2.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
